// File: rtl/aes_ahb_cfg_regs.sv
`default_nettype none
// ============================================================================
// Module   : aes_ahb_cfg_regs
// Purpose  : AHB-Lite slave register file holding NUM_CH independent AES job
//            descriptors (src/dst address, key, size, mode) with per-channel
//            start/busy/done handshake, overflow flag and a shared interrupt.
// Ports    : hclk/hresetn          clock, asynchronous active-low reset
//            hsel..hwdata          AHB-Lite slave inputs
//            hreadyout/hresp/hrdata AHB-Lite slave response
//            src_addr/dst_addr/size_data/key/mode  per-channel descriptors
//            start / core_done     per-channel handshake with the AES core
//            irq                   OR over channels of (done & ie)
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module aes_ahb_cfg_regs #(
    parameter logic [22:0] BASE_HI  = 23'h0,
    parameter int          NUM_CH   = 2,
    parameter int          KEY_BITS = 128
) (
    input  logic                       hclk,
    input  logic                       hresetn,
    input  logic                       hsel,
    input  logic                       hwrite,
    input  logic                       hready,
    input  logic [31:0]                haddr,
    input  logic [1:0]                 htrans,
    input  logic [2:0]                 hsize,
    input  logic [31:0]                hwdata,
    output logic                       hreadyout,
    output logic                       hresp,
    output logic [31:0]                hrdata,
    output logic [NUM_CH*32-1:0]       src_addr,
    output logic [NUM_CH*32-1:0]       dst_addr,
    output logic [NUM_CH*32-1:0]       size_data,
    output logic [NUM_CH*KEY_BITS-1:0] key,
    output logic [NUM_CH*2-1:0]        mode,
    output logic [NUM_CH-1:0]          start,
    input  logic [NUM_CH-1:0]          core_done,
    output logic                       irq
);

    localparam int         c_key_words = KEY_BITS / 32;

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_wdp  = 3'd1;
    localparam logic [2:0] c_st_rdp  = 3'd2;
    localparam logic [2:0] c_st_err1 = 3'd3;
    localparam logic [2:0] c_st_err2 = 3'd4;

    // Word index within a channel's 0x40 window (offset >> 2)
    localparam logic [3:0] c_w_src  = 4'd0;
    localparam logic [3:0] c_w_dst  = 4'd1;
    localparam logic [3:0] c_w_key0 = 4'd2;
    localparam logic [3:0] c_w_size = 4'd10;
    localparam logic [3:0] c_w_ctrl = 4'd11;
    localparam logic [3:0] c_w_stat = 4'd12;

    logic [2:0]  r_state;
    logic [2:0]  r_ch;
    logic [3:0]  r_word;
    logic [31:0] r_hrdata;
    logic        r_irq;

    logic [2:0]  w_ch;
    logic [3:0]  w_word;
    logic        w_base_hit, w_ch_ok, w_word_ok, w_legal, w_accept;
    logic [31:0] w_rd_data;
    logic        w_unused;

    logic [NUM_CH-1:0][31:0] w_rd_ch;
    logic [NUM_CH-1:0]       w_irq_ch;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    assign w_ch       = haddr[8:6];
    assign w_word     = haddr[5:2];
    assign w_base_hit = (haddr[31:9] == BASE_HI);
    assign w_ch_ok    = (32'(w_ch) < 32'(NUM_CH));
    assign w_word_ok  = (w_word == c_w_src) || (w_word == c_w_dst) ||
                        ((w_word >= c_w_key0) && (w_word < c_w_key0 + 4'(c_key_words))) ||
                        (w_word == c_w_size) || (w_word == c_w_ctrl) || (w_word == c_w_stat);
    assign w_legal    = w_base_hit && w_ch_ok && w_word_ok &&
                        (haddr[1:0] == 2'b00) && (hsize == 3'b010);
    assign w_accept   = hsel && hready && htrans[1];
    assign w_unused   = htrans[0];

    // ------------------------------------------------------------------
    // Per-channel register sets
    // ------------------------------------------------------------------
    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            logic [31:0]                  r_src, r_dst, r_size;
            logic [c_key_words-1:0][31:0] r_key;
            logic [1:0]                   r_mode;
            logic                         r_ie, r_busy, r_done, r_ovf, r_start;

            logic [31:0]                  w_src_nxt, w_dst_nxt, w_size_nxt;
            logic [c_key_words-1:0][31:0] w_key_nxt;
            logic [1:0]                   w_mode_nxt;
            logic                         w_ie_nxt, w_busy_nxt, w_done_nxt, w_ovf_nxt;
            logic                         w_sel, w_desc_we, w_ctrl_we, w_stat_we;
            logic                         w_go, w_ovf_set, w_fin;
            logic [31:0]                  w_rd;

            assign w_sel     = (r_state == c_st_wdp) && (r_ch == 3'(c));
            // Descriptor fields (incl. mode/ie) are frozen while a job runs
            assign w_desc_we = w_sel && !r_busy;
            assign w_ctrl_we = w_sel && (r_word == c_w_ctrl);
            assign w_stat_we = w_sel && (r_word == c_w_stat);
            assign w_go      = w_ctrl_we && hwdata[8] && !r_busy;
            assign w_ovf_set = w_ctrl_we && hwdata[8] && r_busy;
            // A completion pulse only counts for a job that is actually running
            assign w_fin     = core_done[c] && r_busy;

            // Next-state values; also feed the read mux so that a read
            // directly behind a write observes the written value.
            always_comb begin
                w_src_nxt  = (w_desc_we && r_word == c_w_src)  ? hwdata : r_src;
                w_dst_nxt  = (w_desc_we && r_word == c_w_dst)  ? hwdata : r_dst;
                w_size_nxt = (w_desc_we && r_word == c_w_size) ? hwdata : r_size;
                w_key_nxt  = r_key;
                for (int k = 0; k < c_key_words; k++) begin
                    if (w_desc_we && (r_word == c_w_key0 + 4'(k)))
                        w_key_nxt[k] = hwdata;
                end
                w_mode_nxt = (w_desc_we && r_word == c_w_ctrl) ? hwdata[1:0] : r_mode;
                w_ie_nxt   = (w_desc_we && r_word == c_w_ctrl) ? hwdata[4]   : r_ie;
                w_busy_nxt = (r_busy && !w_fin) || w_go;
                // Hardware set has priority over the W1C clear
                w_done_nxt = (r_done && !(w_stat_we && hwdata[1])) || w_fin;
                w_ovf_nxt  = (r_ovf  && !(w_stat_we && hwdata[2])) || w_ovf_set;
            end

            always_comb begin
                w_rd = 32'd0;
                case (w_word)
                    c_w_src:  w_rd = w_src_nxt;
                    c_w_dst:  w_rd = w_dst_nxt;
                    c_w_size: w_rd = w_size_nxt;
                    c_w_ctrl: w_rd = {27'd0, w_ie_nxt, 2'b00, w_mode_nxt};
                    c_w_stat: w_rd = {29'd0, w_ovf_nxt, w_done_nxt, w_busy_nxt};
                    default: begin
                        for (int k = 0; k < c_key_words; k++) begin
                            if (w_word == c_w_key0 + 4'(k))
                                w_rd = w_key_nxt[k];
                        end
                    end
                endcase
            end

            always_ff @(posedge hclk or negedge hresetn) begin
                if (!hresetn) begin
                    r_src   <= 32'd0;
                    r_dst   <= 32'd0;
                    r_size  <= 32'd0;
                    r_key   <= '0;
                    r_mode  <= 2'd0;
                    r_ie    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_ovf   <= 1'b0;
                    r_start <= 1'b0;
                end else begin
                    r_src   <= w_src_nxt;
                    r_dst   <= w_dst_nxt;
                    r_size  <= w_size_nxt;
                    r_key   <= w_key_nxt;
                    r_mode  <= w_mode_nxt;
                    r_ie    <= w_ie_nxt;
                    r_busy  <= w_busy_nxt;
                    r_done  <= w_done_nxt;
                    r_ovf   <= w_ovf_nxt;
                    r_start <= w_go;
                end
            end

            assign w_rd_ch[c]              = w_rd;
            assign w_irq_ch[c]             = r_done && r_ie;
            assign src_addr[c*32 +: 32]    = r_src;
            assign dst_addr[c*32 +: 32]    = r_dst;
            assign size_data[c*32 +: 32]   = r_size;
            assign mode[c*2 +: 2]          = r_mode;
            assign start[c]                = r_start;

            // Key word at offset 0x08 is the most significant word
            for (genvar k = 0; k < c_key_words; k++) begin : g_key
                assign key[c*KEY_BITS + (c_key_words-1-k)*32 +: 32] = r_key[k];
            end
        end
    endgenerate

    always_comb begin
        w_rd_data = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_ch == 3'(i))
                w_rd_data = w_rd_ch[i];
        end
    end

    // ------------------------------------------------------------------
    // Transfer FSM and registered read data
    // ------------------------------------------------------------------
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= c_st_idle;
            r_ch     <= 3'd0;
            r_word   <= 4'd0;
            r_hrdata <= 32'd0;
            r_irq    <= 1'b0;
        end else begin
            r_irq <= |w_irq_ch;
            if (r_state == c_st_err1) begin
                r_state <= c_st_err2;
            end else if (w_accept) begin
                r_ch   <= w_ch;
                r_word <= w_word;
                if (w_legal) begin
                    r_state <= hwrite ? c_st_wdp : c_st_rdp;
                    if (!hwrite)
                        r_hrdata <= w_rd_data;
                end else begin
                    r_state <= c_st_err1;
                    if (!hwrite)
                        r_hrdata <= 32'd0;
                end
            end else begin
                r_state <= c_st_idle;
            end
        end
    end

    assign hreadyout = (r_state != c_st_err1);
    assign hresp     = (r_state == c_st_err1) || (r_state == c_st_err2);
    assign hrdata    = r_hrdata;
    assign irq       = r_irq;

endmodule
`default_nettype wire
